// File: rtl/paillier_keygen_seq.sv
// ---------------------------------------------------------------------------
// paillier_keygen_seq
//
// Multi-key Paillier key-generation sequencer. For each of num_keys slots it
// reads a (p,q) prime pair from RAM, computes n = p*q, g = n+1 and
// lambda = (p-1)*(q-1). It then asks an external modular-inverse engine for
// mu = lambda^-1 mod n and writes the finished record to RAM.
//
// Optional feature macro: KEYGEN_PQ_CHECK_EN
//   When defined, pairs with p==q, an even factor, or a factor below 3 are
//   rejected in COMPUTE. A rejected pair sets err and skips the inverse and
//   the write. Its slot still counts toward num_keys, and wr_addr still
//   advances, but keys_done does not.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_keys     run request (sampled in IDLE) and key count
//   busy, done, err     status: not-IDLE, end-of-run pulse, sticky abort
//   keys_done           records written in the current run
//   rd_en, rd_addr      RAM read strobe and address
//   rd_p, rd_q          read data, valid one cycle after rd_en
//   inv_din_*           request channel to the inverse engine
//   inv_base, inv_mod   request payload (lambda, n)
//   inv_dout_*, inv_res response channel from the inverse engine (mu)
//   wr_en, wr_addr      RAM write strobe and address
//   n_out .. mu_out     key record; each holds until the next write
//   dbg_state           current FSM state, for observation only
//
// Handshake semantics (both inverse channels): a transfer happens on a
// rising clk edge where valid and ready are both high. Once valid is raised
// it stays high, with the payload unchanged, until that transfer.
// ---------------------------------------------------------------------------
module paillier_keygen_seq #(
  parameter int                         DATA_WIDTH    = 1024,
  parameter int                         ADDRESS_WIDTH = 64,
  parameter logic [ADDRESS_WIDTH-1:0]   RD_BASE       = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   WR_BASE       = '0,
  parameter int unsigned                INV_TIMEOUT   = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDRESS_WIDTH-1:0]   num_keys,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDRESS_WIDTH-1:0]   keys_done,
  output logic                       rd_en,
  output logic [ADDRESS_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH/2-1:0]    rd_p,
  input  logic [DATA_WIDTH/2-1:0]    rd_q,
  output logic                       inv_din_valid,
  input  logic                       inv_din_ready,
  output logic [DATA_WIDTH-1:0]      inv_base,
  output logic [DATA_WIDTH-1:0]      inv_mod,
  input  logic                       inv_dout_valid,
  output logic                       inv_dout_ready,
  input  logic [DATA_WIDTH-1:0]      inv_res,
  output logic                       wr_en,
  output logic [ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]      n_out,
  output logic [DATA_WIDTH-1:0]      g_out,
  output logic [DATA_WIDTH-1:0]      lambda_out,
  output logic [DATA_WIDTH-1:0]      mu_out,
  output logic [2:0]                 dbg_state
);

  localparam int HW = DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LATCH    = 3'd2,
    COMPUTE  = 3'd3,
    INV_REQ  = 3'd4,
    INV_WAIT = 3'd5,
    WRITE    = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] num_q;
  logic [ADDRESS_WIDTH-1:0] slot_q;       // slots consumed, including rejected pairs
  logic [ADDRESS_WIDTH-1:0] keys_done_q;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [HW-1:0]            p_q;
  logic [HW-1:0]            q_q;
  logic [DATA_WIDTH-1:0]    n_q;
  logic [DATA_WIDTH-1:0]    lambda_q;
  logic [31:0]              wd_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     rd_en_q;
  logic                     din_valid_q;
  logic                     dout_ready_q;
  logic                     wr_en_q;
  logic [DATA_WIDTH-1:0]    n_out_q;
  logic [DATA_WIDTH-1:0]    g_out_q;
  logic [DATA_WIDTH-1:0]    lambda_out_q;
  logic [DATA_WIDTH-1:0]    mu_out_q;

  // Arithmetic on the latched pair; registered in COMPUTE.
  logic [HW-1:0]            p_m1_d;
  logic [HW-1:0]            q_m1_d;
  logic [DATA_WIDTH-1:0]    n_d;
  logic [DATA_WIDTH-1:0]    lambda_d;
  logic                     last_slot_d;
  logic                     wd_expired_d;
  logic                     pq_bad_d;

  assign p_m1_d      = p_q - HW'(1);
  assign q_m1_d      = q_q - HW'(1);
  assign n_d         = DATA_WIDTH'(p_q) * DATA_WIDTH'(q_q);
  assign lambda_d    = DATA_WIDTH'(p_m1_d) * DATA_WIDTH'(q_m1_d);
  assign last_slot_d = ((slot_q + ADDRESS_WIDTH'(1)) == num_q);
  // Counting the current cycle, has INV_WAIT lasted INV_TIMEOUT cycles?
  assign wd_expired_d = (INV_TIMEOUT != 0) && ((wd_q + 32'd1) >= INV_TIMEOUT);

`ifdef KEYGEN_PQ_CHECK_EN
  assign pq_bad_d = (p_q == q_q) || !p_q[0] || !q_q[0] ||
                    (p_q < HW'(3)) || (q_q < HW'(3));
`else
  assign pq_bad_d = 1'b0;
`endif

  // Every output is a register that is loaded on the transition into the
  // state that owns it, so each output is aligned with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      slot_q       <= '0;
      keys_done_q  <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      p_q          <= '0;
      q_q          <= '0;
      n_q          <= '0;
      lambda_q     <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      din_valid_q  <= 1'b0;
      dout_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      n_out_q      <= '0;
      g_out_q      <= '0;
      lambda_out_q <= '0;
      mu_out_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q       <= num_keys;
            slot_q      <= '0;
            keys_done_q <= '0;
            err_q       <= 1'b0;
            rd_addr_q   <= RD_BASE;
            wr_addr_q   <= WR_BASE;
            busy_q      <= 1'b1;
            if (num_keys == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          p_q     <= rd_p;
          q_q     <= rd_q;
          state_q <= COMPUTE;
        end
        COMPUTE: begin
          if (pq_bad_d) begin
            // Rejected pair: consume the slot without a write.
            err_q <= 1'b1;
            if (last_slot_d) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              slot_q    <= slot_q + ADDRESS_WIDTH'(1);
              rd_addr_q <= rd_addr_q + ADDRESS_WIDTH'(1);
              wr_addr_q <= wr_addr_q + ADDRESS_WIDTH'(1);
              rd_en_q   <= 1'b1;
              state_q   <= FETCH;
            end
          end else begin
            n_q         <= n_d;
            lambda_q    <= lambda_d;
            din_valid_q <= 1'b1;
            state_q     <= INV_REQ;
          end
        end
        INV_REQ: begin
          if (inv_din_ready) begin
            din_valid_q  <= 1'b0;
            dout_ready_q <= 1'b1;
            wd_q         <= '0;
            state_q      <= INV_WAIT;
          end
        end
        INV_WAIT: begin
          // A result arriving on the limit cycle takes priority over abort.
          if (inv_dout_valid) begin
            dout_ready_q <= 1'b0;
            n_out_q      <= n_q;
            g_out_q      <= n_q + DATA_WIDTH'(1);
            lambda_out_q <= lambda_q;
            mu_out_q     <= inv_res;
            wr_en_q      <= 1'b1;
            state_q      <= WRITE;
          end else if (wd_expired_d) begin
            dout_ready_q <= 1'b0;
            err_q        <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        WRITE: begin
          keys_done_q <= keys_done_q + ADDRESS_WIDTH'(1);
          if (last_slot_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            slot_q    <= slot_q + ADDRESS_WIDTH'(1);
            rd_addr_q <= rd_addr_q + ADDRESS_WIDTH'(1);
            wr_addr_q <= wr_addr_q + ADDRESS_WIDTH'(1);
            rd_en_q   <= 1'b1;
            state_q   <= FETCH;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign keys_done      = keys_done_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign inv_din_valid  = din_valid_q;
  assign inv_base       = lambda_q;
  assign inv_mod        = n_q;
  assign inv_dout_ready = dout_ready_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign n_out          = n_out_q;
  assign g_out          = g_out_q;
  assign lambda_out     = lambda_out_q;
  assign mu_out         = mu_out_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_paillier_keygen_seq.sv
// ---------------------------------------------------------------------------
// tb_paillier_keygen_seq
//
// Bench for paillier_keygen_seq at DATA_WIDTH=16, ADDRESS_WIDTH=8,
// RD_BASE=4, WR_BASE=16, INV_TIMEOUT=20. A RAM model serves (p,q) pairs,
// and a behavioural inverse responder answers with a configurable ready
// delay and response delay, or never answers. Every write is compared
// against a queue of hand-computed key records.
// ---------------------------------------------------------------------------
module tb_paillier_keygen_seq;

  localparam int         DW  = 16;
  localparam int         AW  = 8;
  localparam logic [7:0] RDB = 8'd4;
  localparam logic [7:0] WRB = 8'd16;
  localparam int         TMO = 20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start;
  logic [AW-1:0] num_keys;
  logic          busy, done, err;
  logic [AW-1:0] keys_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW/2-1:0] rd_p, rd_q;
  logic          inv_din_valid, inv_din_ready;
  logic [DW-1:0] inv_base, inv_mod;
  logic          inv_dout_valid, inv_dout_ready;
  logic [DW-1:0] inv_res;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] n_out, g_out, lambda_out, mu_out;
  logic [2:0]    dbg_state;

  paillier_keygen_seq #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RD_BASE(RDB), .WR_BASE(WRB),
    .INV_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_keys(num_keys),
    .busy(busy), .done(done), .err(err), .keys_done(keys_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_p(rd_p), .rd_q(rd_q),
    .inv_din_valid(inv_din_valid), .inv_din_ready(inv_din_ready),
    .inv_base(inv_base), .inv_mod(inv_mod),
    .inv_dout_valid(inv_dout_valid), .inv_dout_ready(inv_dout_ready),
    .inv_res(inv_res), .wr_en(wr_en), .wr_addr(wr_addr),
    .n_out(n_out), .g_out(g_out), .lambda_out(lambda_out), .mu_out(mu_out),
    .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  p;
    logic [7:0]  q;
    logic [15:0] n;
    logic [15:0] g;
    logic [15:0] lam;
    logic [15:0] mu;
  } vec_t;
  vec_t vecs[4];

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];     // {wr_addr, n, g, lambda, mu}
  logic [7:0]  rd_exp_q[$];  // expected read addresses
  logic [7:0]  p_mem[256];
  logic [7:0]  q_mem[256];
  int rd_cnt, wr_cnt, done_cnt, wait_cnt, req_cnt;

  task automatic load_slot(input logic [7:0] slot, input logic [7:0] p, input logic [7:0] q);
    logic [7:0] a;
    a = RDB + slot;
    p_mem[a] = p;
    q_mem[a] = q;
    rd_exp_q.push_back(a);
  endtask

  task automatic expect_write(input logic [7:0] slot, input int vi);
    logic [7:0] a;
    a = WRB + slot;
    exp_q.push_back({a, vecs[vi].n, vecs[vi].g, vecs[vi].lam, vecs[vi].mu});
  endtask

  // RAM model and write/handshake monitor.
  always @(negedge clk) begin : mon
    logic [71:0] e;
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        rd_p = p_mem[rd_addr];
        rd_q = q_mem[rd_addr];
        check("rd_expected", 32'(rd_exp_q.size() > 0), 32'd1);
        if (rd_exp_q.size() > 0) check("rd_addr", 32'(rd_addr), 32'(rd_exp_q.pop_front()));
      end
      if (wr_en) begin
        wr_cnt++;
        check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr",    32'(wr_addr),    32'(e[71:64]));
          check("wr_n",       32'(n_out),      32'(e[63:48]));
          check("wr_g",       32'(g_out),      32'(e[47:32]));
          check("wr_lambda",  32'(lambda_out), 32'(e[31:16]));
          check("wr_mu",      32'(mu_out),     32'(e[15:0]));
        end
      end
      if (done)           done_cnt++;
      if (inv_dout_ready) wait_cnt++;
      if (inv_din_valid)  req_cnt++;
    end
  end

  // ---------------- behavioural inverse responder ----------------
  int          rsp_phase, rsp_cnt, rsp_ready_delay, rsp_delay, stab_err;
  bit          rsp_never, req_seen;
  logic [15:0] req_b, req_m;

  function automatic logic [15:0] modinv(input logic [15:0] a, input logic [15:0] m);
    logic [15:0] r;
    r = '0;
    for (int x = 1; x < int'(m); x++) begin
      if ((int'(a) * x) % int'(m) == 1) begin
        r = 16'(x);
        break;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      inv_din_ready  = 1'b0;
      inv_dout_valid = 1'b0;
      rsp_phase      = 0;
      req_seen       = 1'b0;
    end else begin
      case (rsp_phase)
        0: begin
          if (req_seen && (!inv_din_valid || inv_base != req_b || inv_mod != req_m)) stab_err++;
          if (inv_din_valid) begin
            if (!req_seen) begin
              req_seen = 1'b1;
              req_b    = inv_base;
              req_m    = inv_mod;
              rsp_cnt  = 0;
            end
            if (rsp_cnt >= rsp_ready_delay) begin
              inv_din_ready = 1'b1;
              req_seen      = 1'b0;
              rsp_phase     = 1;
            end else begin
              rsp_cnt++;
            end
          end
        end
        1: begin
          inv_din_ready = 1'b0;
          rsp_cnt       = 0;
          rsp_phase     = rsp_never ? 0 : 2;
        end
        2: begin
          if (rsp_cnt >= rsp_delay) begin
            inv_dout_valid = 1'b1;
            inv_res        = modinv(req_b, req_m);
            rsp_phase      = 3;
          end else begin
            rsp_cnt++;
          end
        end
        default: begin
          inv_dout_valid = 1'b0;
          rsp_phase      = 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; wait_cnt = 0; req_cnt = 0; stab_err = 0;
  endtask

  task automatic kick(input logic [7:0] nk);
    @(negedge clk);
    num_keys = nk;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedges from the one following the start-sampling edge (=1).
  task automatic wait_done(input string name, input int budget, output int lat);
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 32'(|{busy, done, err, keys_done, rd_en, rd_addr, inv_din_valid,
                     inv_base, inv_mod, inv_dout_ready, wr_en, wr_addr,
                     n_out, g_out, lambda_out, mu_out}), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  int lat;

  initial begin
    vecs[0] = '{p: 8'd7,  q: 8'd11, n: 16'd77,  g: 16'd78,  lam: 16'd60,  mu: 16'd9};
    vecs[1] = '{p: 8'd5,  q: 8'd13, n: 16'd65,  g: 16'd66,  lam: 16'd48,  mu: 16'd42};
    vecs[2] = '{p: 8'd3,  q: 8'd17, n: 16'd51,  g: 16'd52,  lam: 16'd32,  mu: 16'd8};
    vecs[3] = '{p: 8'd11, q: 8'd13, n: 16'd143, g: 16'd144, lam: 16'd120, mu: 16'd87};

    rst_n = 1'b0; start = 1'b0; num_keys = '0;
    rd_p = '0; rd_q = '0; inv_din_ready = 1'b0; inv_dout_valid = 1'b0; inv_res = '0;
    rsp_phase = 0; rsp_cnt = 0; rsp_ready_delay = 0; rsp_delay = 0; rsp_never = 1'b0;
    req_seen = 1'b0; req_b = '0; req_m = '0;
    clear_counts();

    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one key per run; latency is 8 cycles plus response delay.
    for (int i = 0; i < 4; i++) begin
      clear_counts();
      rsp_delay = i;
      load_slot(8'd0, vecs[i].p, vecs[i].q);
      expect_write(8'd0, i);
      kick(8'd1);
      wait_done("vec", 100, lat);
      check("vec_latency", 32'(lat), 32'(i + 8));
      settle();
      check("vec_keys_done", 32'(keys_done), 32'd1);
      check("vec_err", 32'(err), 32'd0);
      check("vec_wr_count", 32'(wr_cnt), 32'd1);
      check("vec_rd_count", 32'(rd_cnt), 32'd1);
      check("vec_done_count", 32'(done_cnt), 32'd1);
      check("vec_busy_idle", 32'(busy), 32'd0);
      check("vec_n_held", 32'(n_out), 32'(vecs[i].n));
    end

    // Three keys: reads 4,5,6 and writes 16,17,18.
    clear_counts();
    rsp_delay = 1;
    for (int s = 0; s < 3; s++) begin
      load_slot(8'(s), vecs[s + 1].p, vecs[s + 1].q);
      expect_write(8'(s), s + 1);
    end
    kick(8'd3);
    wait_done("multi", 200, lat);
    settle();
    check("multi_keys_done", 32'(keys_done), 32'd3);
    check("multi_wr_count", 32'(wr_cnt), 32'd3);
    check("multi_rd_count", 32'(rd_cnt), 32'd3);
    check("multi_done_count", 32'(done_cnt), 32'd1);
    check("multi_err", 32'(err), 32'd0);

    // Zero keys: done right after start, nothing read or written.
    clear_counts();
    kick(8'd0);
    wait_done("zero", 10, lat);
    check("zero_latency", 32'(lat), 32'd1);
    settle();
    check("zero_rd_count", 32'(rd_cnt), 32'd0);
    check("zero_wr_count", 32'(wr_cnt), 32'd0);
    check("zero_keys_done", 32'(keys_done), 32'd0);
    check("zero_done_count", 32'(done_cnt), 32'd1);

    // Request backpressure: ready held low for 10 cycles.
    clear_counts();
    rsp_delay = 0; rsp_ready_delay = 10;
    load_slot(8'd0, vecs[2].p, vecs[2].q);
    expect_write(8'd0, 2);
    kick(8'd1);
    wait_done("bp", 100, lat);
    check("bp_latency", 32'(lat), 32'd18);
    settle();
    check("bp_req_cycles", 32'(req_cnt), 32'd11);
    check("bp_stability", 32'(stab_err), 32'd0);
    check("bp_wr_count", 32'(wr_cnt), 32'd1);
    rsp_ready_delay = 0;

    // Watchdog: no response, abort after 20 INV_WAIT cycles.
    clear_counts();
    rsp_never = 1'b1;
    load_slot(8'd0, vecs[0].p, vecs[0].q);
    kick(8'd1);
    wait_done("wd", 100, lat);
    settle();
    check("wd_err", 32'(err), 32'd1);
    check("wd_wait_cycles", 32'(wait_cnt), 32'(TMO));
    check("wd_wr_count", 32'(wr_cnt), 32'd0);
    check("wd_done_count", 32'(done_cnt), 32'd1);
    check("wd_keys_done", 32'(keys_done), 32'd0);
    check("wd_busy_idle", 32'(busy), 32'd0);

    // Next start clears err and runs normally.
    clear_counts();
    rsp_never = 1'b0;
    load_slot(8'd0, vecs[0].p, vecs[0].q);
    expect_write(8'd0, 0);
    kick(8'd1);
    check("restart_err_cleared", 32'(err), 32'd0);
    wait_done("restart", 100, lat);
    settle();
    check("restart_wr_count", 32'(wr_cnt), 32'd1);
    check("restart_err", 32'(err), 32'd0);

    // Result on the watchdog limit cycle wins over the abort.
    clear_counts();
    rsp_delay = 18;
    load_slot(8'd0, vecs[3].p, vecs[3].q);
    expect_write(8'd0, 3);
    kick(8'd1);
    wait_done("tie", 100, lat);
    check("tie_latency", 32'(lat), 32'd26);
    settle();
    check("tie_err", 32'(err), 32'd0);
    check("tie_wait_cycles", 32'(wait_cnt), 32'(TMO));
    check("tie_wr_count", 32'(wr_cnt), 32'd1);
    rsp_delay = 0;

    // Reset during INV_WAIT.
    clear_counts();
    rsp_never = 1'b1;
    load_slot(8'd0, vecs[1].p, vecs[1].q);
    kick(8'd2);
    lat = 0;
    while (!inv_dout_ready && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("midrst_reached_wait", 32'(inv_dout_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_never = 1'b0;
    settle();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_write", 32'(wr_cnt), 32'd0);
    clear_counts();
    load_slot(8'd0, vecs[1].p, vecs[1].q);
    expect_write(8'd0, 1);
    kick(8'd1);
    wait_done("postrst", 100, lat);
    check("postrst_latency", 32'(lat), 32'd8);
    settle();
    check("postrst_keys_done", 32'(keys_done), 32'd1);
    check("postrst_err", 32'(err), 32'd0);
    check("postrst_done_count", 32'(done_cnt), 32'd1);

`ifdef KEYGEN_PQ_CHECK_EN
    // Rejected pair p=q=7: slot consumed, no write, wr_addr still advances.
    clear_counts();
    load_slot(8'd0, 8'd7, 8'd7);
    load_slot(8'd1, vecs[0].p, vecs[0].q);
    expect_write(8'd1, 0);
    kick(8'd2);
    wait_done("pq", 100, lat);
    settle();
    check("pq_err", 32'(err), 32'd1);
    check("pq_keys_done", 32'(keys_done), 32'd1);
    check("pq_wr_count", 32'(wr_cnt), 32'd1);
    check("pq_rd_count", 32'(rd_cnt), 32'd2);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("rd_exp_q_drained", 32'(rd_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
